mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage. It accepts one instruction per cycle from EX, buffers word stores in a small in-order store queue, and drains that queue into the single-ported data RAM. It issues loads to the RAM and registers results toward WB. It sits directly upstream of the data RAM and drives the RAM's read enable, write enable, load type, address and write data.

## Interface

- `SQ_DEPTH`, 4: store-queue entries (power of two, ≥2)
- `RAM_DEPTH`, 64: valid word addresses are 0..RAM_DEPTH-1

- `clk` in 1: clock; all state updates on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `in_valid` in 1: EX presents an instruction
- `in_ready` out 1: combinational; instruction accepted when `in_valid && in_ready`
- `in_is_load` in 1: load op
- `in_is_store` in 1: word store op (never both with load)
- `in_load_type` in 2: 00 LW, 01 LH, 10 LB, 11 illegal
- `in_addr` in 32: word address (load/store) 
- `in_wdata` in 32: store data, or ALU result for non-memory ops
- `in_rd` in 5: destination register
- `out_valid` out 1: registered; one instruction retiring to WB
- `out_rd` out 5: registered destination
- `out_data` out 32: registered load result or ALU result
- `out_fault` out 1: registered; address out of range or illegal load type
- `ram_read_en`, `ram_write_en` out 1 each: combinational RAM strobes, never both high
- `ram_load_type` out 2, `ram_addr` out 32, `ram_wdata` out 32: combinational RAM controls
- `ram_rdata` in 32: RAM combinational read data, already extended per load type
- `sq_empty` out 1: queue holds no entries (fence/debug)

## Operation

- Store queue: circular buffer of {addr, data}, with head/tail pointers of log2(SQ_DEPTH) bits that wrap, plus a count of log2(SQ_DEPTH)+1 bits.
- Non-memory op: accepted whenever no output stall applies (there is none; WB always accepts).
  - Next cycle: `out_valid`=1, `out_data`=`in_wdata`, `out_fault`=0.
- Store, `in_addr` < RAM_DEPTH:
  - Accepted iff count < SQ_DEPTH. A drain in the same cycle does not free a slot for this cycle's store.
  - On acceptance it is enqueued at tail. Next cycle: `out_valid`=1, `out_rd`=0, `out_data`=0.
- Store, `in_addr` ≥ RAM_DEPTH: accepted and not enqueued. Next cycle: `out_fault`=1, `out_data`=0.
- Load, conditions for issue:
  - Stalled (`in_ready`=0) if its address equals any valid queue entry (hazard), or if count == SQ_DEPTH.
  - Otherwise issued this cycle: `ram_read_en`=1, `ram_addr`=`in_addr`, `ram_load_type`=`in_load_type`.
  - `ram_rdata` is captured into `out_data` at the edge.
- Load fault:
  - Triggered by `in_addr` ≥ RAM_DEPTH or `in_load_type`==11.
  - Accepted without a RAM access; next cycle `out_fault`=1, `out_data`=0.
- Drain: whenever count > 0 and no load is issued this cycle:
  - Assert `ram_write_en`=1 with the head entry's addr/data, then advance the head.
  - Because of the full-queue rule, a full queue always drains, so loads cannot starve stores.
- Hazard compare uses entries valid at the start of the cycle. This includes the entry draining that cycle, so a one-cycle conservative stall is correct.
- Data-path idle values: when no access is made, `ram_addr`/`ram_wdata`/`ram_load_type` are 0.
- Reset mid-operation: queue contents are discarded (count=0, pointers=0); pending stores are lost by design.

## Timing

- Reset values: `out_valid`=0, `out_rd`=0, `out_data`=0, `out_fault`=0, `sq_empty`=1, count/head/tail=0.
- Latency: 1 cycle from acceptance to `out_valid` for every op.
- Throughput: 1 op/cycle absent stalls.
- `out_valid`=0 in any cycle following a cycle with no accepted instruction.
- RAM write for a store occurs ≥1 cycle after acceptance. Drain rate is at most 1 per cycle.
- `in_ready` depends combinationally on `in_valid`-independent state and the `in_*` fields only; it never depends on `ram_rdata`.

## Configuration

- `LSU_STORE_FWD_EN` defined: a load hitting the queue does not stall.
  - Data comes from the youngest matching entry: LW = data, LH = {{16{d[15]}},d[15:0]}, LB = {{24{d[7]}},d[7:0]}.
  - No RAM read is made, so a drain may proceed that cycle.
  - The full-queue load stall remains.
- Undefined: hazard loads stall until the matching entries have drained.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → all outputs 0, `sq_empty`=1, no RAM strobes.
- Store addr 5 data 0xDEADBEEF, then idle → enqueued; next cycle `ram_write_en`=1, `ram_addr`=5, `ram_wdata`=0xDEADBEEF; `sq_empty` returns to 1.
- Five back-to-back stores with a continuous load stream to a disjoint address.
  - Expected: queue fills to 4; the 5th store sees `in_ready`=0; a drain occurs every full cycle; loads stall while the queue is full.
- Store addr 9 data 0x0000_8081, then LH addr 9.
  - Without macro: load stalls until the write, then `out_data`=0xFFFF_8081.
  - With macro: no stall, `out_data`=0xFFFF_8081, `ram_read_en`=0.
- Load addr 64, and separately load type 11 → `out_fault`=1, `out_data`=0, no RAM strobe.
- Queue at count 3: assert `rst_n`=0 for one cycle → count 0, no further `ram_write_en`.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Bundle for the MEM-stage LSU: EX request, WB result and data-RAM port.
// The LSU uses the slave modport; the environment (EX/WB/RAM) uses master.
interface mem_stage_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_load_type;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_fault;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [1:0]  ram_load_type;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        sq_empty;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_load_type, in_addr, in_wdata, in_rd, ram_rdata,
    output in_ready, out_valid, out_rd, out_data, out_fault,
           ram_read_en, ram_write_en, ram_load_type, ram_addr, ram_wdata, sq_empty
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_load_type, in_addr, in_wdata, in_rd, ram_rdata,
    input  in_ready, out_valid, out_rd, out_data, out_fault,
           ram_read_en, ram_write_en, ram_load_type, ram_addr, ram_wdata, sq_empty
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: in-order word store queue drained into a
// single-ported data RAM, loads issued directly, one result per cycle to WB.
// Optional macro LSU_STORE_FWD_EN: loads hitting the store queue are served
// from the youngest matching entry instead of stalling.
module mem_stage_lsu #(
  parameter int SQ_DEPTH  = 4,
  parameter int RAM_DEPTH = 64
) (
  input logic           clk,
  input logic           rst_n,
  mem_stage_lsu_if.slave bus
);
  localparam int PW = $clog2(SQ_DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   sq_addr_q [SQ_DEPTH];
  logic [31:0]   sq_data_q [SQ_DEPTH];

  logic          out_valid_q, out_valid_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_fault_q, out_fault_d;

  logic addr_oor, load_fault, store_fault, sq_full, sq_hit;
  logic ready, accept, load_issue, drain, enqueue;
`ifdef LSU_STORE_FWD_EN
  logic [31:0] hit_data;

  function automatic logic [31:0] fwd_extend(input logic [31:0] d, input logic [1:0] lt);
    case (lt)
      2'b01:   fwd_extend = {{16{d[15]}}, d[15:0]};
      2'b10:   fwd_extend = {{24{d[7]}}, d[7:0]};
      default: fwd_extend = d;
    endcase
  endfunction
`endif

  // Scan entries valid at the start of the cycle, oldest to youngest, for an address match
  always_comb begin
    sq_hit = 1'b0;
`ifdef LSU_STORE_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < SQ_DEPTH; k++) begin
      if (((PW+1)'(k) < count_q) && (sq_addr_q[head_q + PW'(k)] == bus.in_addr)) begin
        sq_hit = 1'b1;
`ifdef LSU_STORE_FWD_EN
        hit_data = sq_data_q[head_q + PW'(k)];
`endif
      end
    end
  end

  // Decode, acceptance and RAM port arbitration (a load issue blocks the drain)
  always_comb begin
    addr_oor    = bus.in_addr >= 32'(RAM_DEPTH);
    load_fault  = bus.in_is_load && (addr_oor || (bus.in_load_type == 2'b11));
    store_fault = bus.in_is_store && addr_oor;
    sq_full     = count_q == (PW+1)'(SQ_DEPTH);
    if (bus.in_is_store) begin
      ready = store_fault || !sq_full;
    end else if (bus.in_is_load) begin
`ifdef LSU_STORE_FWD_EN
      ready = load_fault || !sq_full;
`else
      ready = load_fault || (!sq_full && !sq_hit);
`endif
    end else begin
      ready = 1'b1;
    end
    accept     = rst_n && bus.in_valid && ready;
`ifdef LSU_STORE_FWD_EN
    load_issue = accept && bus.in_is_load && !load_fault && !sq_hit;
`else
    load_issue = accept && bus.in_is_load && !load_fault;
`endif
    drain      = rst_n && (count_q != '0) && !load_issue;
    enqueue    = accept && bus.in_is_store && !store_fault;
  end

  assign bus.in_ready      = ready;
  assign bus.ram_read_en   = load_issue;
  assign bus.ram_write_en  = drain;
  assign bus.ram_load_type = load_issue ? bus.in_load_type : 2'b00;
  assign bus.ram_addr      = load_issue ? bus.in_addr : (drain ? sq_addr_q[head_q] : 32'd0);
  assign bus.ram_wdata     = drain ? sq_data_q[head_q] : 32'd0;
  assign bus.sq_empty      = count_q == '0;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_fault     = out_fault_q;

  // Next-state for queue pointers and the WB result register
  always_comb begin
    head_d      = drain ? head_q + PW'(1) : head_q;
    tail_d      = enqueue ? tail_q + PW'(1) : tail_q;
    count_d     = count_q + {{PW{1'b0}}, enqueue} - {{PW{1'b0}}, drain};
    out_valid_d = accept;
    out_rd_d    = '0;
    out_data_d  = '0;
    out_fault_d = 1'b0;
    if (accept) begin
      if (bus.in_is_store) begin
        out_fault_d = store_fault;
      end else if (bus.in_is_load) begin
        out_rd_d = bus.in_rd;
        if (load_fault) begin
          out_fault_d = 1'b1;
`ifdef LSU_STORE_FWD_EN
        end else if (sq_hit) begin
          out_data_d = fwd_extend(hit_data, bus.in_load_type);
`endif
        end else begin
          out_data_d = bus.ram_rdata;
        end
      end else begin
        out_rd_d   = bus.in_rd;
        out_data_d = bus.in_wdata;
      end
    end
  end

  // Control and result registers; reset discards all queued stores
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_fault_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

  // Queue storage is written at the tail on enqueue; contents beyond count are don't-care
  always_ff @(posedge clk) begin
    if (enqueue) begin
      sq_addr_q[tail_q] <= bus.in_addr;
      sq_data_q[tail_q] <= bus.in_wdata;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_mem_stage_lsu;
  localparam int SQD = 4;
  localparam int RD  = 64;

  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.SQ_DEPTH(SQD), .RAM_DEPTH(RD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // RAM environment: seeded contents, combinational extended read, write on edge
  logic [31:0] seed [RD];
  logic [31:0] ram [RD];
  logic        ram_seeded = 1'b0;

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] t);
    case (t)
      2'b00:   ext = d;
      2'b01:   ext = {{16{d[15]}}, d[15:0]};
      2'b10:   ext = {{24{d[7]}}, d[7:0]};
      default: ext = 32'd0;
    endcase
  endfunction

  assign bus.ram_rdata = ext(ram[bus.ram_addr[5:0]], bus.ram_load_type);

  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < RD; i++) ram[i] <= seed[i];
      ram_seeded <= 1'b1;
    end else if (bus.ram_write_en) begin
      ram[bus.ram_addr[5:0]] <= bus.ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending stores and a shadow memory
  st_t         mq[$];
  logic [31:0] refmem [RD];
  logic        model_seeded = 1'b0;
  logic        armed = 1'b0;
  logic        e_valid, e_fault;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  always @(negedge clk) begin
    logic hit, full, fl, fs, rdy, acc, ld, drn;
    logic [31:0] fwd, x_addr, x_wdata;
    logic [1:0]  x_type;
    if (!model_seeded) begin
      for (int i = 0; i < RD; i++) refmem[i] = seed[i];
      model_seeded = 1'b1;
    end
    if (armed) begin
      chk("out_valid", bus.out_valid, e_valid);
      chk("out_rd", bus.out_rd, e_rd);
      chk("out_data", bus.out_data, e_data);
      chk("out_fault", bus.out_fault, e_fault);
      chk("sq_empty", bus.sq_empty, mq.size() == 0);
    end
    hit = 1'b0;
    fwd = 32'd0;
    foreach (mq[i]) if (mq[i].addr == bus.in_addr) begin hit = 1'b1; fwd = mq[i].data; end
    full = mq.size() == SQD;
    fl   = bus.in_is_load && (bus.in_addr >= RD || bus.in_load_type == 2'b11);
    fs   = bus.in_is_store && bus.in_addr >= RD;
    if (bus.in_is_store) rdy = fs || !full;
`ifdef LSU_STORE_FWD_EN
    else if (bus.in_is_load) rdy = fl || !full;
`else
    else if (bus.in_is_load) rdy = fl || (!full && !hit);
`endif
    else rdy = 1'b1;
    acc = rst_n && bus.in_valid && rdy;
`ifdef LSU_STORE_FWD_EN
    ld  = acc && bus.in_is_load && !fl && !hit;
`else
    ld  = acc && bus.in_is_load && !fl;
`endif
    drn = rst_n && mq.size() > 0 && !ld;
    x_addr  = ld ? bus.in_addr : (drn ? mq[0].addr : 32'd0);
    x_wdata = drn ? mq[0].data : 32'd0;
    x_type  = ld ? bus.in_load_type : 2'b00;
    if (rst_n && armed) chk("in_ready", bus.in_ready, rdy);
    chk("ram_read_en", bus.ram_read_en, ld);
    chk("ram_write_en", bus.ram_write_en, drn);
    if (armed) begin
      chk("ram_addr", bus.ram_addr, x_addr);
      chk("ram_wdata", bus.ram_wdata, x_wdata);
      chk("ram_load_type", bus.ram_load_type, x_type);
    end
    e_valid = acc; e_rd = 5'd0; e_data = 32'd0; e_fault = 1'b0;
    if (!rst_n) begin
      mq.delete();
      armed = 1'b1;
    end else begin
      if (acc) begin
        if (bus.in_is_store) e_fault = fs;
        else if (bus.in_is_load) begin
          e_rd = bus.in_rd;
          if (fl) e_fault = 1'b1;
          else if (!ld) e_data = ext(fwd, bus.in_load_type);
          else e_data = ext(refmem[bus.in_addr[5:0]], bus.in_load_type);
        end else begin
          e_rd = bus.in_rd;
          e_data = bus.in_wdata;
        end
      end
      if (drn) begin
        refmem[mq[0].addr[5:0]] = mq[0].data;
        void'(mq.pop_front());
      end
      if (acc && bus.in_is_store && !fs) mq.push_back('{addr: bus.in_addr, data: bus.in_wdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 ALU, 1 store, 2 load
  task automatic drive(input int kind, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic [1:0] lt);
    bus.in_valid     = 1'b1;
    bus.in_is_store  = (kind == 1);
    bus.in_is_load   = (kind == 2);
    bus.in_addr      = a;
    bus.in_wdata     = d;
    bus.in_rd        = rd;
    bus.in_load_type = lt;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.in_is_store = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < RD; i++) seed[i] = $urandom;
    rst_n = 1'b0;
    drive(2, 32'd3, 32'd0, 5'd1, 2'b00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_rd", bus.out_rd, 5'd0);
    chk("rst_out_fault", bus.out_fault, 1'b0);
    chk("rst_sq_empty", bus.sq_empty, 1'b1);
    chk("rst_no_read", bus.ram_read_en, 1'b0);
    chk("rst_no_write", bus.ram_write_en, 1'b0);
    step();
    rst_n = 1'b1;
    idle();
    step();

    // ALU op
    drive(0, 32'd0, 32'h1234_5678, 5'd4, 2'b00);
    step();
    idle();
    @(negedge clk);
    chk("alu_valid", bus.out_valid, 1'b1);
    chk("alu_data", bus.out_data, 32'h1234_5678);
    chk("alu_rd", bus.out_rd, 5'd4);

    // single store then drain
    step();
    drive(1, 32'd5, 32'hDEAD_BEEF, 5'd9, 2'b00);
    @(negedge clk);
    chk("st_ready", bus.in_ready, 1'b1);
    chk("st_no_write_same_cycle", bus.ram_write_en, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("st_out_valid", bus.out_valid, 1'b1);
    chk("st_out_rd", bus.out_rd, 5'd0);
    chk("st_out_data", bus.out_data, 32'd0);
    chk("st_drain_en", bus.ram_write_en, 1'b1);
    chk("st_drain_addr", bus.ram_addr, 32'd5);
    chk("st_drain_data", bus.ram_wdata, 32'hDEAD_BEEF);
    chk("st_sq_busy", bus.sq_empty, 1'b0);
    step();
    @(negedge clk);
    chk("st_sq_empty_again", bus.sq_empty, 1'b1);
    chk("st_single_drain", bus.ram_write_en, 1'b0);

    // store then dependent LH
    step();
    drive(1, 32'd9, 32'h0000_8081, 5'd0, 2'b00);
    step();
    drive(2, 32'd9, 32'd0, 5'd7, 2'b01);
    @(negedge clk);
`ifdef LSU_STORE_FWD_EN
    chk("hz_fwd_ready", bus.in_ready, 1'b1);
    chk("hz_fwd_no_read", bus.ram_read_en, 1'b0);
    chk("hz_fwd_drain", bus.ram_write_en, 1'b1);
    step();
`else
    chk("hz_stall", bus.in_ready, 1'b0);
    chk("hz_drain", bus.ram_write_en, 1'b1);
    chk("hz_drain_addr", bus.ram_addr, 32'd9);
    step();
    @(negedge clk);
    chk("hz_ready_after", bus.in_ready, 1'b1);
    chk("hz_read", bus.ram_read_en, 1'b1);
    chk("hz_read_addr", bus.ram_addr, 32'd9);
    chk("hz_read_type", bus.ram_load_type, 2'b01);
    step();
`endif
    idle();
    @(negedge clk);
    chk("hz_valid", bus.out_valid, 1'b1);
    chk("hz_data", bus.out_data, 32'hFFFF_8081);
    chk("hz_rd", bus.out_rd, 5'd7);

    // faulting loads
    step();
    drive(2, 32'd64, 32'd0, 5'd3, 2'b00);
    @(negedge clk);
    chk("flt_oor_ready", bus.in_ready, 1'b1);
    chk("flt_oor_no_read", bus.ram_read_en, 1'b0);
    step();
    drive(2, 32'd2, 32'd0, 5'd3, 2'b11);
    @(negedge clk);
    chk("flt_oor_fault", bus.out_fault, 1'b1);
    chk("flt_oor_data", bus.out_data, 32'd0);
    chk("flt_type_no_read", bus.ram_read_en, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("flt_type_fault", bus.out_fault, 1'b1);
    chk("flt_type_data", bus.out_data, 32'd0);

    // reset with a store pending
    step();
    drive(1, 32'd12, 32'hCAFE_F00D, 5'd0, 2'b00);
    step();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_no_write", bus.ram_write_en, 1'b0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_sq_empty", bus.sq_empty, 1'b1);
    chk("mrst_no_write_after", bus.ram_write_en, 1'b0);
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int kind;
      logic [31:0] a;
      rst_n = ($urandom_range(0, 199) != 0);
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(64, 300)) : 32'($urandom_range(0, 7));
      drive(kind, a, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    rst_n = 1'b1;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
